// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
//
// Main controller for a multicycle RV32I datapath. It walks each instruction
// through fetch, decode, execute, memory and writeback. It drives every
// datapath strobe and mux select, and it produces the two-bit ALU_Op code
// that the ALU control decoder combines with funct3/funct7.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset, forces FETCH
//   opcode[6:0] in   IR[6:0], stable from DECODE until the next fetch completes
//   funct3[2:0] in   IR[14:12]
//   zero        in   ALU zero flag for the current cycle
//   mem_ready   in   memory completes the current request this cycle
//   ALU_Op[1:0] out  00 add, 01 sub, 10 decode funct3/funct7
//   pc_write    out  PC load strobe
//   ir_write    out  IR / old_pc load strobe
//   mem_read    out  memory read request
//   mem_write   out  memory write request
//   reg_write   out  register file write strobe
//   adr_src     out  memory address select: 0 PC, 1 ALUOut
//   alu_src_a   out  00 PC, 01 old_pc, 10 rs1 latch, 11 constant 0
//   alu_src_b   out  00 rs2 latch, 01 immediate, 10 constant 4
//   result_src  out  00 ALUOut, 01 memory data, 10 ALU result
//   imm_src     out  000 I, 001 S, 010 B, 011 J, 100 U (from opcode only)
//   illegal     out  high while the FSM sits in TRAP
// ---------------------------------------------------------------------------
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] ALU_Op,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       illegal
);

    // RV32I major opcodes handled by this controller
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU_Op codes
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_DECODE = 2'b10;

    // ALU operand A selects
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCA_ZERO   = 2'b11;

    // ALU operand B selects
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result mux selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Immediate format selects
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_U,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_A,
        S_JALR_B,
        S_TRAP
    } state_t;

    state_t state;
    state_t next_state;

    // Only BEQ and BNE are implemented. funct3[0] selects the sense of
    // the zero test, so the upper two bits must both be clear.
    logic branch_legal;
    assign branch_legal = (funct3[2:1] == 2'b00);

    // State register. Reset is asynchronous so that an in-flight memory
    // request is withdrawn in the same cycle that reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The memory-facing states wait on mem_ready. TRAP is
    // a sink that only reset can leave.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OPC_LOAD,
                    OPC_STORE:  next_state = S_MEMADR;
                    OPC_OP:     next_state = S_EXEC_R;
                    OPC_OP_IMM: next_state = S_EXEC_I;
                    OPC_BRANCH: next_state = S_BRANCH;
                    OPC_JAL:    next_state = S_JAL;
                    OPC_JALR:   next_state = S_JALR_A;
                    OPC_LUI,
                    OPC_AUIPC:  next_state = S_EXEC_U;
                    default:    next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                // Only loads and stores reach this state, so anything that
                // is not a load must be a store.
                next_state = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXEC_R:   next_state = S_ALUWB;
            S_EXEC_I:   next_state = S_ALUWB;
            S_EXEC_U:   next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = branch_legal ? S_FETCH : S_TRAP;
            S_JAL:      next_state = S_ALUWB;
            S_JALR_A:   next_state = S_JALR_B;
            S_JALR_B:   next_state = S_ALUWB;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    // Output logic. Most outputs are Moore. The exceptions are the FETCH
    // handshake strobes, which wait on mem_ready, and the branch pc_write,
    // which depends on zero. The FETCH strobes are also masked by rst_n.
    // Without that mask, a mem_ready that is already high while reset is
    // asserted could load the PC or the IR.
    always_comb begin
        ALU_Op     = ALU_ADD;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                adr_src  = 1'b0;
                if (mem_ready && rst_n) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    ALU_Op     = ALU_ADD;
                    result_src = RES_ALU;
                end
            end
            S_DECODE: begin
                // Precompute the branch/JAL target into ALUOut
                alu_src_a = SRCA_OLD_PC;
                alu_src_b = SRCB_IMM;
                ALU_Op    = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                ALU_Op    = ALU_ADD;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                ALU_Op    = ALU_DECODE;
            end
            S_EXEC_I: begin
                // For ADDI, IR[30] is immediate data. The ALU decoder would
                // read it as the SUB bit, so add is forced here instead.
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                ALU_Op    = (funct3 == 3'b000) ? ALU_ADD : ALU_DECODE;
            end
            S_EXEC_U: begin
                // LUI adds the immediate to 0. AUIPC adds it to the
                // instruction's own PC.
                alu_src_a = (opcode == OPC_LUI) ? SRCA_ZERO : SRCA_OLD_PC;
                alu_src_b = SRCB_IMM;
                ALU_Op    = ALU_ADD;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                ALU_Op     = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write   = branch_legal & (zero ^ funct3[0]);
            end
            S_JAL, S_JALR_B: begin
                // The PC loads the target held in ALUOut. In the same cycle
                // the ALU forms old_pc + 4 as the link value.
                alu_src_a  = SRCA_OLD_PC;
                alu_src_b  = SRCB_FOUR;
                ALU_Op     = ALU_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
            end
            S_JALR_A: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                ALU_Op    = ALU_ADD;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    // Immediate format select depends only on the opcode. Formats without an
    // immediate, and illegal opcodes, fall back to I.
    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OPC_LOAD,
            OPC_OP_IMM,
            OPC_JALR:   imm_src = IMM_I;
            OPC_STORE:  imm_src = IMM_S;
            OPC_BRANCH: imm_src = IMM_B;
            OPC_JAL:    imm_src = IMM_J;
            OPC_LUI,
            OPC_AUIPC:  imm_src = IMM_U;
            default:    imm_src = IMM_I;
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_control_fsm
//
// Directed bench for the multicycle main controller. Each step drives the
// inputs on the falling clock edge and then compares all outputs 1 ns later
// against a hand-written expected vector. The rising edge that follows
// advances the FSM.
// ---------------------------------------------------------------------------
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALU_Op;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       illegal;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BAD    = 7'b0000000;

    // Expected control word, field order:
    // ALU_Op[2] pc_write ir_write mem_read mem_write reg_write adr_src
    // alu_src_a[2] alu_src_b[2] result_src[2] illegal
    localparam logic [14:0] E_FETCH_WAIT = {2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_FETCH_GO   = {2'b00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,1'b0};
    localparam logic [14:0] E_DECODE     = {2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,1'b0};
    localparam logic [14:0] E_MEMADR     = {2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,1'b0};
    localparam logic [14:0] E_MEMREAD    = {2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_MEMWB      = {2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b01,1'b0};
    localparam logic [14:0] E_MEMWRITE   = {2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_EXEC_R     = {2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_EXEC_I_ADD = {2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,1'b0};
    localparam logic [14:0] E_EXEC_I_DEC = {2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,1'b0};
    localparam logic [14:0] E_EXEC_LUI   = {2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b01,2'b00,1'b0};
    localparam logic [14:0] E_EXEC_AUIPC = {2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,1'b0};
    localparam logic [14:0] E_ALUWB      = {2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_BR_TAKEN   = {2'b01,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_BR_NOT     = {2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_JUMP       = {2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,1'b0};
    localparam logic [14:0] E_JALR_A     = {2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,1'b0};
    localparam logic [14:0] E_TRAP       = {2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1};

    logic [17:0] observed;
    assign observed = {ALU_Op, pc_write, ir_write, mem_read, mem_write, reg_write,
                       adr_src, alu_src_a, alu_src_b, result_src, illegal, imm_src};

    main_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ALU_Op     (ALU_Op),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .illegal    (illegal)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Drive one set of inputs on the falling edge, then let them settle
    task automatic applyStimulus(input logic r, input logic mr, input logic [6:0] op,
                                 input logic [2:0] f3, input logic z);
        @(negedge clk);
        rst_n     = r;
        mem_ready = mr;
        opcode    = op;
        funct3    = f3;
        zero      = z;
        #1;
    endtask

    // Compare every output against the expected control word and imm_src
    task automatic checkOutput(input string tag, input logic [14:0] ectl, input logic [2:0] eimm);
        logic [17:0] expected;
        expected = {ectl, eimm};
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic mr, input logic [6:0] op,
                        input logic [2:0] f3, input logic z,
                        input logic [14:0] ectl, input logic [2:0] eimm);
        applyStimulus(r, mr, op, f3, z);
        checkOutput(tag, ectl, eimm);
    endtask

    // Directed instruction sequence
    initial begin
        $display("[TB] main_control_fsm directed test start");
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        opcode    = OPC_BAD;
        funct3    = 3'b000;
        zero      = 1'b0;
        #1 rst_n  = 1'b0;

        // Reset holds FETCH with only mem_read asserted
        step("reset",        0, 0, OPC_BAD,    3'b000, 0, E_FETCH_WAIT, 3'b000);
        step("reset_mr1",    0, 1, OPC_BAD,    3'b000, 0, E_FETCH_WAIT, 3'b000);
        step("release",      1, 0, OPC_OP,     3'b000, 0, E_FETCH_WAIT, 3'b000);

        // ADD: FETCH DECODE EXEC_R ALUWB
        step("add_fetch",    1, 1, OPC_OP,     3'b000, 0, E_FETCH_GO,   3'b000);
        step("add_decode",   1, 1, OPC_OP,     3'b000, 0, E_DECODE,     3'b000);
        step("add_exec",     1, 1, OPC_OP,     3'b000, 0, E_EXEC_R,     3'b000);
        step("add_wb",       1, 1, OPC_OP,     3'b000, 0, E_ALUWB,      3'b000);

        // ADDI forces add. SRAI defers to the ALU decoder.
        step("addi_fetch",   1, 1, OPC_OP_IMM, 3'b000, 0, E_FETCH_GO,   3'b000);
        step("addi_decode",  1, 1, OPC_OP_IMM, 3'b000, 0, E_DECODE,     3'b000);
        step("addi_exec",    1, 1, OPC_OP_IMM, 3'b000, 0, E_EXEC_I_ADD, 3'b000);
        step("addi_wb",      1, 1, OPC_OP_IMM, 3'b000, 0, E_ALUWB,      3'b000);
        step("srai_fetch",   1, 1, OPC_OP_IMM, 3'b101, 0, E_FETCH_GO,   3'b000);
        step("srai_decode",  1, 1, OPC_OP_IMM, 3'b101, 0, E_DECODE,     3'b000);
        step("srai_exec",    1, 1, OPC_OP_IMM, 3'b101, 0, E_EXEC_I_DEC, 3'b000);
        step("srai_wb",      1, 1, OPC_OP_IMM, 3'b101, 0, E_ALUWB,      3'b000);

        // LW with 3 fetch stalls and 2 MEMREAD stalls: 10 cycles
        step("lw_stall0",    1, 0, OPC_LOAD,   3'b010, 0, E_FETCH_WAIT, 3'b000);
        step("lw_stall1",    1, 0, OPC_LOAD,   3'b010, 0, E_FETCH_WAIT, 3'b000);
        step("lw_stall2",    1, 0, OPC_LOAD,   3'b010, 0, E_FETCH_WAIT, 3'b000);
        step("lw_fetch",     1, 1, OPC_LOAD,   3'b010, 0, E_FETCH_GO,   3'b000);
        step("lw_decode",    1, 1, OPC_LOAD,   3'b010, 0, E_DECODE,     3'b000);
        step("lw_memadr",    1, 1, OPC_LOAD,   3'b010, 0, E_MEMADR,     3'b000);
        step("lw_rdstall0",  1, 0, OPC_LOAD,   3'b010, 0, E_MEMREAD,    3'b000);
        step("lw_rdstall1",  1, 0, OPC_LOAD,   3'b010, 0, E_MEMREAD,    3'b000);
        step("lw_read",      1, 1, OPC_LOAD,   3'b010, 0, E_MEMREAD,    3'b000);
        step("lw_wb",        1, 1, OPC_LOAD,   3'b010, 0, E_MEMWB,      3'b000);

        // Branches: BEQ and BNE with zero set, then BNE with zero clear
        step("beq_fetch",    1, 1, OPC_BRANCH, 3'b000, 1, E_FETCH_GO,   3'b010);
        step("beq_decode",   1, 1, OPC_BRANCH, 3'b000, 1, E_DECODE,     3'b010);
        step("beq_taken",    1, 1, OPC_BRANCH, 3'b000, 1, E_BR_TAKEN,   3'b010);
        step("bne_fetch",    1, 1, OPC_BRANCH, 3'b001, 1, E_FETCH_GO,   3'b010);
        step("bne_decode",   1, 1, OPC_BRANCH, 3'b001, 1, E_DECODE,     3'b010);
        step("bne_not",      1, 1, OPC_BRANCH, 3'b001, 1, E_BR_NOT,     3'b010);
        step("bne2_fetch",   1, 1, OPC_BRANCH, 3'b001, 0, E_FETCH_GO,   3'b010);
        step("bne2_decode",  1, 1, OPC_BRANCH, 3'b001, 0, E_DECODE,     3'b010);
        step("bne2_taken",   1, 1, OPC_BRANCH, 3'b001, 0, E_BR_TAKEN,   3'b010);

        // JALR: JALR_A JALR_B ALUWB
        step("jalr_fetch",   1, 1, OPC_JALR,   3'b000, 0, E_FETCH_GO,   3'b000);
        step("jalr_decode",  1, 1, OPC_JALR,   3'b000, 0, E_DECODE,     3'b000);
        step("jalr_a",       1, 1, OPC_JALR,   3'b000, 0, E_JALR_A,     3'b000);
        step("jalr_b",       1, 1, OPC_JALR,   3'b000, 0, E_JUMP,       3'b000);
        step("jalr_wb",      1, 1, OPC_JALR,   3'b000, 0, E_ALUWB,      3'b000);

        // JAL, LUI, AUIPC
        step("jal_fetch",    1, 1, OPC_JAL,    3'b000, 0, E_FETCH_GO,   3'b011);
        step("jal_decode",   1, 1, OPC_JAL,    3'b000, 0, E_DECODE,     3'b011);
        step("jal_jump",     1, 1, OPC_JAL,    3'b000, 0, E_JUMP,       3'b011);
        step("jal_wb",       1, 1, OPC_JAL,    3'b000, 0, E_ALUWB,      3'b011);
        step("lui_fetch",    1, 1, OPC_LUI,    3'b000, 0, E_FETCH_GO,   3'b100);
        step("lui_decode",   1, 1, OPC_LUI,    3'b000, 0, E_DECODE,     3'b100);
        step("lui_exec",     1, 1, OPC_LUI,    3'b000, 0, E_EXEC_LUI,   3'b100);
        step("lui_wb",       1, 1, OPC_LUI,    3'b000, 0, E_ALUWB,      3'b100);
        step("auipc_fetch",  1, 1, OPC_AUIPC,  3'b000, 0, E_FETCH_GO,   3'b100);
        step("auipc_decode", 1, 1, OPC_AUIPC,  3'b000, 0, E_DECODE,     3'b100);
        step("auipc_exec",   1, 1, OPC_AUIPC,  3'b000, 0, E_EXEC_AUIPC, 3'b100);
        step("auipc_wb",     1, 1, OPC_AUIPC,  3'b000, 0, E_ALUWB,      3'b100);

        // SW aborted by reset while stalled in MEMWRITE
        step("sw_fetch",     1, 1, OPC_STORE,  3'b010, 0, E_FETCH_GO,   3'b001);
        step("sw_decode",    1, 1, OPC_STORE,  3'b010, 0, E_DECODE,     3'b001);
        step("sw_memadr",    1, 1, OPC_STORE,  3'b010, 0, E_MEMADR,     3'b001);
        step("sw_wrstall",   1, 0, OPC_STORE,  3'b010, 0, E_MEMWRITE,   3'b001);
        step("sw_abort",     0, 0, OPC_STORE,  3'b010, 0, E_FETCH_WAIT, 3'b001);
        step("sw_restart",   1, 0, OPC_STORE,  3'b010, 0, E_FETCH_WAIT, 3'b001);

        // Complete SW with no stall
        step("sw2_fetch",    1, 1, OPC_STORE,  3'b010, 0, E_FETCH_GO,   3'b001);
        step("sw2_decode",   1, 1, OPC_STORE,  3'b010, 0, E_DECODE,     3'b001);
        step("sw2_memadr",   1, 1, OPC_STORE,  3'b010, 0, E_MEMADR,     3'b001);
        step("sw2_write",    1, 1, OPC_STORE,  3'b010, 0, E_MEMWRITE,   3'b001);

        // Branch with unsupported funct3 goes to TRAP and stays there
        step("blt_fetch",    1, 1, OPC_BRANCH, 3'b100, 1, E_FETCH_GO,   3'b010);
        step("blt_decode",   1, 1, OPC_BRANCH, 3'b100, 1, E_DECODE,     3'b010);
        step("blt_branch",   1, 1, OPC_BRANCH, 3'b100, 1, E_BR_NOT,     3'b010);
        step("blt_trap",     1, 1, OPC_BRANCH, 3'b100, 1, E_TRAP,       3'b010);
        step("blt_hold",     1, 1, OPC_BRANCH, 3'b100, 1, E_TRAP,       3'b010);
        step("trap_reset",   0, 0, OPC_BAD,    3'b000, 0, E_FETCH_WAIT, 3'b000);

        // Illegal opcode 0000000
        step("bad_fetch",    1, 1, OPC_BAD,    3'b000, 0, E_FETCH_GO,   3'b000);
        step("bad_decode",   1, 1, OPC_BAD,    3'b000, 0, E_DECODE,     3'b000);
        step("bad_trap",     1, 1, OPC_BAD,    3'b000, 0, E_TRAP,       3'b000);
        step("bad_hold",     1, 1, OPC_BAD,    3'b000, 0, E_TRAP,       3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
